// File: rtl/axi_slave_pkg.sv
// axi_slave_pkg: shared burst/resp constants, FSM state encodings and grant type for the AXI slave arbiter
package axi_slave_pkg;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_WR_DATA  = 3'd1;
    localparam logic [2:0] ST_WR_RESP  = 3'd2;
    localparam logic [2:0] ST_RD_ISSUE = 3'd3;
    localparam logic [2:0] ST_RD_WAIT  = 3'd4;
    localparam logic [2:0] ST_RD_RESP  = 3'd5;
    typedef enum logic {GRANT_WRITE = 1'b0, GRANT_READ = 1'b1} grant_t;
endpackage

// File: rtl/axi_burst_addr_gen.sv
// axi_burst_addr_gen: combinational next-beat address (addr,len,size,burst in; next_addr out) for FIXED/INCR/WRAP
module axi_burst_addr_gen
    import axi_slave_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        len,
    input  logic [2:0]        size,
    input  logic [1:0]        burst,
    output logic [ADDR_W-1:0] next_addr
);
    logic [ADDR_W-1:0] step, mask, incr;
    always_comb begin
        step = ADDR_W'(1) << size;
        mask = ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);
        incr = addr + step;
        next_addr = burst == BURST_FIXED ? addr :
                    burst == BURST_WRAP  ? (addr & ~mask) | (incr & mask) : incr;
    end
endmodule

// File: rtl/axi_slave_rw_arbiter.sv
// axi_slave_rw_arbiter: AXI4 slave (AW/W/B/AR/R) to single-port beat bus (mem_req/ready/we/addr/wdata/wstrb/rvalid/rdata), round-robin R/W
module axi_slave_rw_arbiter
    import axi_slave_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 12
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                axi_slave_awvalid,
    output logic                axi_slave_awready,
    input  logic [ADDR_W-1:0]   axi_slave_awaddr,
    input  logic [7:0]          axi_slave_awlen,
    input  logic [2:0]          axi_slave_awsize,
    input  logic [1:0]          axi_slave_awburst,
    input  logic [ID_W-1:0]     axi_slave_awid,
    input  logic                axi_slave_wvalid,
    output logic                axi_slave_wready,
    input  logic [DATA_W-1:0]   axi_slave_wdata,
    input  logic [DATA_W/8-1:0] axi_slave_wstrb,
    input  logic                axi_slave_wlast,
    output logic                axi_slave_bvalid,
    input  logic                axi_slave_bready,
    output logic [ID_W-1:0]     axi_slave_bid,
    output logic [1:0]          axi_slave_bresp,
    input  logic                axi_slave_arvalid,
    output logic                axi_slave_arready,
    input  logic [ADDR_W-1:0]   axi_slave_araddr,
    input  logic [7:0]          axi_slave_arlen,
    input  logic [2:0]          axi_slave_arsize,
    input  logic [1:0]          axi_slave_arburst,
    input  logic [ID_W-1:0]     axi_slave_arid,
    output logic                axi_slave_rvalid,
    input  logic                axi_slave_rready,
    output logic [ID_W-1:0]     axi_slave_rid,
    output logic [1:0]          axi_slave_rresp,
    output logic [DATA_W-1:0]   axi_slave_rdata,
    output logic                axi_slave_rlast,
    output logic                mem_req,
    input  logic                mem_ready,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata
);
    logic [2:0]        state;
    grant_t            last_grant;
    logic [ADDR_W-1:0] addr_q, next_addr;
    logic [7:0]        len_q, cnt;
    logic [2:0]        size_q;
    logic [1:0]        burst_q;
    logic [ID_W-1:0]   id_q;
    logic [DATA_W-1:0] rdata_q;
    logic              wr_gnt, rd_gnt, last_beat, unused_wlast;
    assign unused_wlast = axi_slave_wlast;
    assign wr_gnt = state == ST_IDLE && axi_slave_awvalid && (!axi_slave_arvalid || last_grant == GRANT_READ);
    assign rd_gnt = state == ST_IDLE && axi_slave_arvalid && (!axi_slave_awvalid || last_grant == GRANT_WRITE);
    assign last_beat = cnt == len_q;
    assign axi_slave_awready = wr_gnt;
    assign axi_slave_arready = rd_gnt;
    assign axi_slave_wready  = state == ST_WR_DATA && mem_ready;
    assign axi_slave_bvalid  = state == ST_WR_RESP;
    assign axi_slave_bid     = id_q;
    assign axi_slave_bresp   = RESP_OKAY;
    assign axi_slave_rvalid  = state == ST_RD_RESP;
    assign axi_slave_rid     = id_q;
    assign axi_slave_rresp   = RESP_OKAY;
    assign axi_slave_rdata   = rdata_q;
    assign axi_slave_rlast   = state == ST_RD_RESP && last_beat;
    assign mem_req   = (state == ST_WR_DATA && axi_slave_wvalid) || state == ST_RD_ISSUE;
    assign mem_we    = state == ST_WR_DATA;
    assign mem_addr  = addr_q;
    assign mem_wdata = axi_slave_wdata;
    assign mem_wstrb = state == ST_WR_DATA ? axi_slave_wstrb : '0;
    axi_burst_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
        .addr      (addr_q),
        .len       (len_q),
        .size      (size_q),
        .burst     (burst_q),
        .next_addr (next_addr)
    );
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= ST_IDLE;
            last_grant <= GRANT_READ;
            addr_q     <= '0;
            len_q      <= '0;
            size_q     <= '0;
            burst_q    <= '0;
            id_q       <= '0;
            cnt        <= '0;
            rdata_q    <= '0;
        end else begin
            case (state)
                ST_IDLE: if (wr_gnt || rd_gnt) begin
                    addr_q     <= wr_gnt ? axi_slave_awaddr  : axi_slave_araddr;
                    len_q      <= wr_gnt ? axi_slave_awlen   : axi_slave_arlen;
                    size_q     <= wr_gnt ? axi_slave_awsize  : axi_slave_arsize;
                    burst_q    <= wr_gnt ? axi_slave_awburst : axi_slave_arburst;
                    id_q       <= wr_gnt ? axi_slave_awid    : axi_slave_arid;
                    cnt        <= '0;
                    last_grant <= wr_gnt ? GRANT_WRITE : GRANT_READ;
                    state      <= wr_gnt ? ST_WR_DATA : ST_RD_ISSUE;
                end
                ST_WR_DATA: if (axi_slave_wvalid && mem_ready) begin
                    addr_q <= next_addr;
                    cnt    <= cnt + 8'd1;
                    if (last_beat) state <= ST_WR_RESP;
                end
                ST_WR_RESP: if (axi_slave_bready) state <= ST_IDLE;
                ST_RD_ISSUE: if (mem_ready) state <= ST_RD_WAIT;
                ST_RD_WAIT: if (mem_rvalid) begin
                    rdata_q <= mem_rdata;
                    state   <= ST_RD_RESP;
                end
                ST_RD_RESP: if (axi_slave_rready) begin
                    if (last_beat) state <= ST_IDLE;
                    else begin
                        addr_q <= next_addr;
                        cnt    <= cnt + 8'd1;
                        state  <= ST_RD_ISSUE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
